// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mem_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0
// ============================================================================
package dsp_mem_pkg;

    localparam int DEF_AW     = 16;
    localparam int DEF_DW     = 16;
    localparam int NUM_REQ    = 2;
    localparam int REQ_LOADER = 0;
    localparam int REQ_DSP    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e grant_state(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester, memory and statistics bundle of the data-memory arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_arbiter_if
    import dsp_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic          req_0;
    logic          we_0;
    logic [AW-1:0] addr_0;
    logic [DW-1:0] wdata_0;
    logic          gnt_0;
    logic [DW-1:0] rdata_0;
    logic          rvalid_0;

    logic          req_1;
    logic          we_1;
    logic [AW-1:0] addr_1;
    logic [DW-1:0] wdata_1;
    logic          gnt_1;
    logic [DW-1:0] rdata_1;
    logic          rvalid_1;

    logic [AW-1:0] mem_read_addr;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_en;
    logic [DW-1:0] mem_read_data;

    logic [15:0]   gnt_cnt_0;
    logic [15:0]   gnt_cnt_1;

    modport slave (
        input  req_0, we_0, addr_0, wdata_0,
        input  req_1, we_1, addr_1, wdata_1,
        output gnt_0, rdata_0, rvalid_0,
        output gnt_1, rdata_1, rvalid_1,
        output mem_read_addr, mem_write_addr, mem_write_data, mem_write_en,
        input  mem_read_data,
        output gnt_cnt_0, gnt_cnt_1
    );

    modport master (
        output req_0, we_0, addr_0, wdata_0,
        output req_1, we_1, addr_1, wdata_1,
        input  gnt_0, rdata_0, rvalid_0,
        input  gnt_1, rdata_1, rvalid_1,
        input  mem_read_addr, mem_write_addr, mem_write_data, mem_write_en,
        output mem_read_data,
        input  gnt_cnt_0, gnt_cnt_1
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr2
// Brief    : Two-way round-robin winner select holding the last-grant pointer.
// Revision : 1.0
// ============================================================================
module arb_rr2
    import dsp_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic       any_o,
    output logic       win_o
);

    logic last_q;

    // Pointer starts at the DSP so the loader wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= upd_idx_i;
        end
    end

    always_comb begin
        any_o = |req_i;
        if (req_i[REQ_LOADER] && req_i[REQ_DSP]) begin
            win_o = ~last_q;
        end else begin
            win_o = req_i[REQ_DSP];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-requester data-memory arbiter, round-robin with burst cap.
//            Grant statistics are built only with DMEM_ARBITER_STATS_EN.
// Revision : 1.0
// ============================================================================
module dmem_arbiter
    import dsp_mem_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_e          state_q;
    logic [7:0]          beat_cnt_q;
    logic [NUM_REQ-1:0]  rvalid_q;
    logic [DW-1:0]       rdata_q [NUM_REQ];

    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_we;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [NUM_REQ-1:0]  w_acc;
    logic [AW-1:0]       w_addr  [NUM_REQ];
    logic [DW-1:0]       w_wdata [NUM_REQ];
    logic                w_own;
    logic                w_own_req;
    logic                w_oth_req;
    logic                w_any;
    logic                w_win;

    assign w_req      = {bus.req_1, bus.req_0};
    assign w_we       = {bus.we_1,  bus.we_0};
    assign w_addr[0]  = bus.addr_0;
    assign w_addr[1]  = bus.addr_1;
    assign w_wdata[0] = bus.wdata_0;
    assign w_wdata[1] = bus.wdata_1;

    assign w_gnt[REQ_LOADER] = (state_q == GRANT0);
    assign w_gnt[REQ_DSP]    = (state_q == GRANT1);
    assign w_acc             = w_req & w_gnt;

    // Owner index is only meaningful outside IDLE.
    assign w_own     = (state_q == GRANT1);
    assign w_own_req = w_req[w_own];
    assign w_oth_req = w_req[~w_own];

    arb_rr2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (w_req),
        .upd_i     (state_q != IDLE),
        .upd_idx_i (w_own),
        .any_o     (w_any),
        .win_o     (w_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (w_any) begin
                        state_q <= grant_state(w_win);
                    end
                end
                GRANT0, GRANT1: begin
                    if (!w_own_req) begin
                        beat_cnt_q <= '0;
                        state_q    <= w_oth_req ? grant_state(~w_own) : IDLE;
                    end else if (beat_cnt_q == BURST_LAST) begin
                        // Burst cap: hand over if the other side waits, else restart.
                        beat_cnt_q <= '0;
                        if (w_oth_req) begin
                            state_q <= grant_state(~w_own);
                        end
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_read_addr  = '0;
        bus.mem_write_addr = '0;
        bus.mem_write_data = '0;
        bus.mem_write_en   = 1'b0;
        if (state_q != IDLE) begin
            bus.mem_read_addr  = w_addr[w_own];
            bus.mem_write_addr = w_addr[w_own];
            bus.mem_write_data = w_wdata[w_own];
            bus.mem_write_en   = w_own_req & w_we[w_own];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                rdata_q[k] <= '0;
            end
        end else begin
            rvalid_q <= w_acc & ~w_we;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_acc[k] && !w_we[k]) begin
                    rdata_q[k] <= bus.mem_read_data;
                end
            end
        end
    end

    assign bus.gnt_0    = w_gnt[REQ_LOADER];
    assign bus.gnt_1    = w_gnt[REQ_DSP];
    assign bus.rvalid_0 = rvalid_q[REQ_LOADER];
    assign bus.rvalid_1 = rvalid_q[REQ_DSP];
    assign bus.rdata_0  = rdata_q[REQ_LOADER];
    assign bus.rdata_1  = rdata_q[REQ_DSP];

`ifdef DMEM_ARBITER_STATS_EN
    logic [15:0] gnt_cnt_q [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                gnt_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_acc[k] && (gnt_cnt_q[k] != 16'hFFFF)) begin
                    gnt_cnt_q[k] <= gnt_cnt_q[k] + 16'd1;
                end
            end
        end
    end

    assign bus.gnt_cnt_0 = gnt_cnt_q[REQ_LOADER];
    assign bus.gnt_cnt_1 = gnt_cnt_q[REQ_DSP];
`else
    assign bus.gnt_cnt_0 = '0;
    assign bus.gnt_cnt_1 = '0;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 16, memory address width.
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive beats granted to one requester while the other waits; legal range 1..255.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: clk, input, 1, clock; rst_n, input, 1, async active-low reset.
REQ-005 Requester k (k=0 sample loader, k=1 DSP) SHALL have these ports: req_k in 1; we_k in 1; addr_k in AW; wdata_k in DW; gnt_k out 1; rdata_k out DW; rvalid_k out 1.
REQ-006 Memory side ports: mem_read_addr out AW; mem_write_addr out AW; mem_write_data out DW; mem_write_en out 1; mem_read_data in DW (combinational read).
REQ-007 Statistics ports: gnt_cnt_0 out 16, gnt_cnt_1 out 16, count of beats accepted per requester.

Function
REQ-008 FSM states: IDLE, GRANT0, GRANT1; registered on clk.
REQ-009 gnt_k SHALL be 1 only in GRANTk, decoded from the state register.
REQ-010 A beat is accepted in a cycle where req_k && gnt_k; the beat's address, we and wdata SHALL be sampled in that same cycle.
REQ-011 In GRANTk, mem_read_addr and mem_write_addr SHALL equal addr_k, mem_write_data SHALL equal wdata_k, and mem_write_en SHALL equal req_k && we_k. In IDLE, all memory outputs SHALL be 0.
REQ-012 For an accepted read beat (we_k=0), rdata_k SHALL be registered from mem_read_data, and rvalid_k SHALL pulse high for exactly one cycle in the next cycle; read latency is 1.
REQ-013 rdata_k SHALL hold its last value when rvalid_k=0.
REQ-014 IDLE: if any req is high, the next state SHALL be GRANT of the winner; if none is high, stay in IDLE; arbitration latency is 1 cycle.
REQ-015 Round-robin: when both req are high, the requester not most recently granted SHALL win; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-016 In GRANTk, an 8-bit beat counter SHALL increment per accepted beat and clear on every state change.
REQ-017 In GRANTk, if req_k=0 the next state SHALL be GRANT(other) if the other req is high, else IDLE.
REQ-018 In GRANTk, if beat count reaches MAX_BURST and the other req is high, the next state SHALL be GRANT(other); if the other req is low, the counter SHALL clear and GRANTk SHALL continue.
REQ-019 Switching directly GRANT0 to GRANT1 (or the reverse) SHALL take no idle cycle.
REQ-020 A requester SHALL hold addr/we/wdata stable while req_k=1 and gnt_k=0; the block does not check this.

Reset
REQ-021 On rst_n=0: state IDLE, pointer=1, beat counter 0, gnt_k 0, rvalid_k 0, rdata_k 0, stats 0, all memory outputs 0.
REQ-022 Reset asserted mid-burst SHALL abort the burst; no write SHALL occur while rst_n=0, and a pending rvalid SHALL be dropped.
REQ-023 After rst_n deasserts, the first grant SHALL occur at the earliest 1 cycle after a req is sampled.

Configuration
REQ-024 Macro DMEM_ARBITER_STATS_EN: when defined, gnt_cnt_k SHALL count accepted beats and saturate at 16'hFFFF; when undefined, gnt_cnt_k SHALL be tied to 0 and the counters SHALL not be synthesized.

Structure
REQ-025 Shared package dsp_mem_pkg SHALL hold the FSM state enum (IDLE/GRANT0/GRANT1), the default AW/DW constants and the requester index constants.
REQ-026 One sub-module, arb_rr2 (2-way round-robin winner select with pointer update), SHALL be instantiated once; the FSM, mux and read registers stay in dmem_arbiter.

Verification
REQ-027 req_0 write, addr=0x0010, wdata=0xBEEF from IDLE -> gnt_0 is high next cycle; mem_write_en=1, mem_write_addr=0x0010, mem_write_data=0xBEEF in that cycle.
REQ-028 req_1 read at addr=0x0020 with mem_read_data=0x1234 -> rdata_1=0x1234 and rvalid_1=1 for 1 cycle, one cycle after acceptance.
REQ-029 Both req high from reset -> grant order is 0 then 1; requester 0 keeps the grant 8 beats, then GRANT1 with no idle cycle.
REQ-030 req_0 alone held for 20 cycles -> GRANT0 is held continuously with no gaps.
REQ-031 rst_n pulled low during the 3rd beat of a write burst -> mem_write_en=0 immediately; after release, state is IDLE with all outputs 0.
REQ-032 With the macro defined, 5 beats on requester 0 and 3 beats on requester 1 -> gnt_cnt_0=5 and gnt_cnt_1=3; with the macro undefined, both read 0.
